// File: rtl/integ_dump_pkg.sv
// integ_dump_pkg -- shared width constants for the integrate-and-dump path.
// integ_dump and the downstream integ_shifter both import these defaults, so
// their widths stay consistent. Only constants live here; there are no typedefs.
package integ_dump_pkg;

  // Default input sample width (two's complement).
  localparam int bw_default         = 16;

  // Default accumulator headroom. A dump can hold at most 2^8 samples.
  localparam int maxbitgain_default = 8;

  // Width of the rate port. The dump period is rate+1 samples.
  localparam int rate_w             = 8;

endpackage

// File: rtl/integ_dump.sv
// integ_dump -- integrate-and-dump decimator.
// Sums rate+1 strobed samples, sign-extended, into a wide accumulator. On the
// final sample of a period it dumps the full sum to signal_out and starts over.
//
// Ports
//   clock      : single clock; every register updates on the rising edge
//   reset      : synchronous, active-high; overrides enable and strobe_in
//   enable     : low holds the block cleared (acc/cnt zero, no strobe_out)
//   rate       : dump length minus one, read live on every strobe
//   strobe_in  : qualifies signal_in for one cycle
//   signal_in  : bw-bit signed sample
//   strobe_out : one-cycle pulse, one clock after the dumping strobe_in
//   signal_out : bw+maxbitgain-bit signed sum; held between dumps
module integ_dump
  import integ_dump_pkg::*;
#(
  parameter int bw         = bw_default,
  parameter int maxbitgain = maxbitgain_default
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [rate_w-1:0]              rate,
  input  logic                           strobe_in,
  input  logic signed [bw-1:0]           signal_in,
  output logic                           strobe_out,
  output logic signed [bw+maxbitgain-1:0] signal_out
);

  localparam int aw = bw + maxbitgain;

  logic signed [aw-1:0]     acc;
  logic        [rate_w-1:0] cnt;
  logic signed [aw-1:0]     sample_ext;
  logic signed [aw-1:0]     sum;
  logic                     dump;

  // maxbitgain bits of headroom cover 2^maxbitgain full-scale samples, so this
  // sum cannot wrap. No saturation logic is needed.
  assign sample_ext = {{maxbitgain{signal_in[bw-1]}}, signal_in};
  assign sum        = acc + sample_ext;

  // Compare with >= rather than ==. If rate is lowered below cnt mid-period,
  // the next strobe dumps at once instead of wrapping through 255.
  assign dump       = (cnt >= rate);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      signal_out <= '0;
      strobe_out <= 1'b0;
    end else if (!enable) begin
      // Drop any strobe that arrives while disabled. signal_out keeps the
      // last dump.
      acc        <= '0;
      cnt        <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (strobe_in) begin
        if (dump) begin
          signal_out <= sum;
          acc        <= '0;
          cnt        <= '0;
          strobe_out <= 1'b1;
        end else begin
          acc        <= sum;
          cnt        <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_integ_dump.sv
// tb_integ_dump -- scoreboard bench for integ_dump at default widths (16+8).
// The bench pushes each expected dump value before it drives the strobe that
// should cause the dump. A monitor on the falling edge pops one entry for every
// strobe_out it sees.
module tb_integ_dump;
  import integ_dump_pkg::*;

  localparam int bw = bw_default;
  localparam int mg = maxbitgain_default;
  localparam int aw = bw + mg;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [rate_w-1:0]      rate;
  logic                   strobe_in;
  logic signed [bw-1:0]   signal_in;
  logic                   strobe_out;
  logic signed [aw-1:0]   signal_out;
  logic [aw-1:0]          so_u;

  int vectors = 0;
  int miscompares = 0;
  logic [aw-1:0] exp_q[$];

  assign so_u = signal_out;

  integ_dump #(.bw(bw), .maxbitgain(mg)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .signal_in  (signal_in),
    .strobe_out (strobe_out),
    .signal_out (signal_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each strobe_out must match the oldest expected dump.
  always @(negedge clock) begin
    if (strobe_out === 1'b1) begin
      if (exp_q.size() == 0)
        check_val("unexpected_strobe", 64'd1, 64'd0);
      else
        check_val("dump_value", 64'(so_u), 64'(exp_q.pop_front()));
    end
  end

  // The tasks below start and end 1ns after a rising edge.
  task automatic send(input logic signed [bw-1:0] v);
    strobe_in = 1'b1;
    signal_in = v;
    @(posedge clock); #1;
    strobe_in = 1'b0;
  endtask

  task automatic send_n(input logic signed [bw-1:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // The dump pulse must appear in the cycle right after the final strobe.
  // By the next falling edge the monitor must have drained the queue.
  task automatic drain(input string tag);
    @(negedge clock); #1;
    check_val(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; rate = 8'd0; strobe_in = 1'b1; signal_in = 16'sd123;
    @(posedge clock); #1;
    @(posedge clock); #1;
    strobe_in = 1'b0;
    @(negedge clock);
    check_val("reset_strobe_out", 64'(strobe_out), 64'd0);
    check_val("reset_signal_out", 64'(so_u), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    rate = 8'd3;
    send(16'sd1); send(16'sd2); send(16'sd3);
    exp_q.push_back(24'd10);
    send(16'sd4);
    drain("r3_latency");
    idle(3);
    @(negedge clock);
    check_val("r3_hold", 64'(so_u), 64'd10);
    @(posedge clock); #1;

    rate = 8'd255;
    send_n(-16'sd32768, 255);
    exp_q.push_back(24'h800000);
    send(-16'sd32768);
    drain("r255_neg");
    send_n(16'sd32767, 255);
    exp_q.push_back(24'h7FFF00);
    send(16'sd32767);
    drain("r255_pos");

    rate = 8'd0;
    exp_q.push_back(24'hFFFFFB);
    send(-16'sd5);
    drain("r0_first");
    idle(1);
    exp_q.push_back(24'h000007);
    send(16'sd7);
    drain("r0_second");

    // Reset mid-period with a strobe held high. The reset must win, and the
    // partial sum must be dropped.
    rate = 8'd7;
    send_n(16'sd100, 3);
    reset = 1'b1; strobe_in = 1'b1; signal_in = 16'sd50;
    @(posedge clock); #1;
    reset = 1'b0; strobe_in = 1'b0;
    @(negedge clock);
    check_val("midreset_strobe", 64'(strobe_out), 64'd0);
    check_val("midreset_signal", 64'(so_u), 64'd0);
    @(posedge clock); #1;
    send_n(16'sd1, 7);
    exp_q.push_back(24'd8);
    send(16'sd1);
    drain("after_reset");

    // Lower rate below cnt mid-period.
    rate = 8'd7;
    send_n(16'sd2, 5);
    rate = 8'd2;
    exp_q.push_back(24'd12);
    send(16'sd2);
    drain("rate_lowered");

    // Raise rate mid-period: the period stretches.
    rate = 8'd1;
    send(16'sd3);
    rate = 8'd3;
    send_n(16'sd3, 2);
    exp_q.push_back(24'd12);
    send(16'sd3);
    drain("rate_raised");

    // Drop enable mid-period while strobe_in stays high.
    rate = 8'd3;
    send_n(16'sd5, 2);
    enable = 1'b0; strobe_in = 1'b1; signal_in = 16'sd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("dis_strobe_out", 64'(strobe_out), 64'd0);
      check_val("dis_hold", 64'(so_u), 64'd12);
    end
    @(posedge clock); #1;
    strobe_in = 1'b0;
    enable = 1'b1;
    send_n(16'sd1, 3);
    exp_q.push_back(24'd4);
    send(16'sd1);
    drain("reenable_full");

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/integ_dump.md
INTEG_DUMP -- requirements
Module: integ_dump

Interface
REQ-001 Parameter bw, default 16: input sample width, two's complement.
REQ-002 Parameter maxbitgain, default 8: accumulator headroom bits; supports at most 2^maxbitgain samples per dump.
REQ-003 Port clock, input, 1: single clock; every register is updated on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: high enables operation; low holds the block in its cleared state.
REQ-006 Port rate, input, 8: dump length minus one, so the dump period is rate+1 input samples (1..256).
REQ-007 Port strobe_in, input, 1: qualifies signal_in for one cycle.
REQ-008 Port signal_in, input, bw: input sample.
REQ-009 Port strobe_out, input/output -- output, 1: one-cycle pulse marking a valid signal_out.
REQ-010 Port signal_out, output, bw+maxbitgain: signed sum of the last rate+1 samples; feeds the downstream bit-gain shifter unmodified.

Function
REQ-011 Internal state: accumulator acc (bw+maxbitgain bits, signed) and sample counter cnt (8 bits).
REQ-012 The block shall sign-extend signal_in to bw+maxbitgain bits before every addition.
REQ-013 On a strobe_in cycle with cnt < rate, it shall set acc <= acc + sample and cnt <= cnt + 1.
REQ-014 On a strobe_in cycle with cnt >= rate (the dump), it shall:
 - set signal_out <= acc + sample;
 - clear acc to 0 and cnt to 0;
 - assert strobe_out.
REQ-015 strobe_out shall be high for exactly the one cycle after a dump cycle and low otherwise; latency is 1 clock from the final strobe_in.
REQ-016 signal_out shall hold its value between dumps.
REQ-017 Without strobe_in, acc, cnt and signal_out shall hold.
REQ-018 rate shall be read live through the comparison cnt >= rate:
 - lowering rate below cnt mid-period dumps on the next strobe_in;
 - raising rate extends the current period.
REQ-019 rate=0 shall pass each sample through sign-extended, with strobe_out following every strobe_in by one cycle.
REQ-020 With rate=255 and all samples at -2^(bw-1), the sum shall be exactly -2^(bw+maxbitgain-1); the block shall not saturate and no overflow is possible within spec.
REQ-021 While enable is low, the block shall clear acc and cnt, force strobe_out to 0, and hold signal_out.
REQ-022 On the rising edge of enable, the first sample after it starts a fresh period.
REQ-023 A strobe_in coinciding with enable low shall be discarded.

Reset
REQ-024 While reset is high at a clock edge: acc=0, cnt=0, signal_out=0, strobe_out=0.
REQ-025 reset shall override enable and strobe_in.
REQ-026 A reset asserted mid-period shall discard the partial sum, and no strobe_out shall follow it.

Structure
REQ-027 The default values of bw and maxbitgain shall live in a shared constants include so that this block and the downstream shifter use the same widths; no typedefs are required.
REQ-028 The block shall be a single module with no sub-modules; the counter/compare and the accumulator are inline.
REQ-029 The block shall be pairable with integ_shifter, with signal_out wired to its signal_in and the same rate wired to both.

Verification
REQ-030 rate=3, samples 1,2,3,4 on consecutive strobes -> one strobe_out, one cycle after the 4th strobe, with signal_out=10.
REQ-031 rate=255, 256 samples of -32768 -> signal_out=-8388608 (0x800000), no wrap; then 256 samples of 32767 -> 8388352.
REQ-032 rate=0, samples -5,7 spaced 3 cycles apart -> two strobe_out pulses, each 1 cycle after its strobe_in, with signal_out = 0xFFFFFB, then 0x000007.
REQ-033 rate=7; after 3 samples of 100, assert reset for 1 cycle; then 8 samples of 1 -> no strobe_out until the 8th sample, then signal_out=8.
REQ-034 rate=7, 5 samples of 2 accumulated, then rate changed to 2 -> the next strobe_in with sample 2 dumps signal_out=12.
REQ-035 enable dropped mid-period with strobe_in held high -> strobe_out stays 0 and signal_out holds; after enable returns, a full rate+1 samples are required before the next dump.
